// File: rtl/rf_wb_scoreboard_if.sv
// Bundle of decode, writeback and register-file write-port signals around the
// writeback scoreboard. The slave side is the scoreboard and the master side is its environment.
interface rf_wb_scoreboard_if #(
    parameter int XLEN    = 32,
    parameter int NUM_SRC = 3
);
    logic                    dec_valid;
    logic [4:0]              dec_rs1_addr;
    logic                    dec_rs1_rd_en;
    logic [4:0]              dec_rs2_addr;
    logic                    dec_rs2_rd_en;
    logic [4:0]              dec_rd_addr;
    logic                    dec_rd_wr_en;
    logic                    dec_stall;

    logic [NUM_SRC-1:0]      wb_valid;
    logic [NUM_SRC*5-1:0]    wb_rd_addr;
    logic [NUM_SRC*XLEN-1:0] wb_data;
    logic [NUM_SRC-1:0]      wb_ready;

    logic [4:0]              rf_rd_addr;
    logic [XLEN-1:0]         rf_rd_data;
    logic                    rf_wr_en;
    logic [31:0]             busy_vec;

    modport slave (
        input  dec_valid, dec_rs1_addr, dec_rs1_rd_en, dec_rs2_addr, dec_rs2_rd_en,
               dec_rd_addr, dec_rd_wr_en, wb_valid, wb_rd_addr, wb_data,
        output dec_stall, wb_ready, rf_rd_addr, rf_rd_data, rf_wr_en, busy_vec
    );

    modport master (
        output dec_valid, dec_rs1_addr, dec_rs1_rd_en, dec_rs2_addr, dec_rs2_rd_en,
               dec_rd_addr, dec_rd_wr_en, wb_valid, wb_rd_addr, wb_data,
        input  dec_stall, wb_ready, rf_rd_addr, rf_rd_data, rf_wr_en, busy_vec
    );
endinterface

// File: rtl/rf_wb_scoreboard.sv
// Register-file write-port sequencer. It arbitrates the writeback sources round-robin onto
// the single write port and keeps the busy scoreboard that stalls decode on RAW/WAW hazards.
module rf_wb_scoreboard #(
    parameter int XLEN    = 32,
    parameter int NUM_SRC = 3
) (
    input  logic                clk,
    input  logic                rst,
    rf_wb_scoreboard_if.slave   bus
);
    localparam int IDX_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

    logic [31:0]        busy_q;
    logic [31:0]        busy_next;
    logic [IDX_W-1:0]   rr_q;
    logic [IDX_W-1:0]   rr_next;
    logic               rf_wr_en_q;
    logic [4:0]         rf_addr_q;
    logic [XLEN-1:0]    rf_data_q;

    logic               hazard;
    logic               issue;
    logic               grant_found;
    logic [NUM_SRC-1:0] grant;
    logic [4:0]         sel_addr;
    logic [XLEN-1:0]    sel_data;

    assign hazard = bus.dec_valid &
                    ((bus.dec_rs1_rd_en & busy_q[bus.dec_rs1_addr]) |
                     (bus.dec_rs2_rd_en & busy_q[bus.dec_rs2_addr]) |
                     (bus.dec_rd_wr_en  & busy_q[bus.dec_rd_addr]));

    assign issue = bus.dec_valid & ~hazard & bus.dec_rd_wr_en & (bus.dec_rd_addr != 5'd0);

    // Scan the sources starting at the round-robin pointer; the first valid one wins.
    always_comb begin
        int idx;
        grant       = '0;
        grant_found = 1'b0;
        sel_addr    = '0;
        sel_data    = '0;
        rr_next     = rr_q;
        for (int k = 0; k < NUM_SRC; k++) begin
            idx = int'(rr_q) + k;
            if (idx >= NUM_SRC) begin
                idx = idx - NUM_SRC;
            end
            if (!grant_found && bus.wb_valid[idx]) begin
                grant_found = 1'b1;
                grant[idx]  = 1'b1;
                sel_addr    = bus.wb_rd_addr[5*idx +: 5];
                sel_data    = bus.wb_data[XLEN*idx +: XLEN];
                rr_next     = (idx == NUM_SRC - 1) ? '0 : IDX_W'(idx + 1);
            end
        end
    end

    // A set from issue is applied after the clear from the write port, so set wins.
    always_comb begin
        busy_next = busy_q;
        if (rf_wr_en_q) begin
            busy_next[rf_addr_q] = 1'b0;
        end
        if (issue) begin
            busy_next[bus.dec_rd_addr] = 1'b1;
        end
        busy_next[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q     <= '0;
            rr_q       <= '0;
            rf_wr_en_q <= 1'b0;
            rf_addr_q  <= '0;
            rf_data_q  <= '0;
        end else begin
            busy_q     <= busy_next;
            rr_q       <= rr_next;
            rf_wr_en_q <= grant_found;
            if (grant_found) begin
                rf_addr_q <= sel_addr;
                rf_data_q <= sel_data;
            end
        end
    end

    assign bus.dec_stall  = hazard;
    assign bus.wb_ready   = grant;
    assign bus.rf_wr_en   = rf_wr_en_q;
    assign bus.rf_rd_addr = rf_addr_q;
    assign bus.rf_rd_data = rf_data_q;
    assign bus.busy_vec   = busy_q;
endmodule
